// File: rtl/fifo_rr_bank.sv
// fifo_rr_bank: round-robin bank of circular-buffer lanes forming one FIFO, with occupancy count and flush.
module fifo_rr_bank #(
  parameter int WIDTH = 704,
  parameter int LANES = 2,
  parameter int LANE_DEPTH = 1,
  localparam int CW = $clog2(LANES * LANE_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq_ena_i,
  input  logic [WIDTH-1:0] in_enq_v_i,
  output logic             in_enq_rdy_o,
  input  logic             out_deq_ena_i,
  output logic             out_deq_rdy_o,
  output logic [WIDTH-1:0] out_first_o,
  output logic             out_first_rdy_o,
  input  logic             flush_ena_i,
  output logic             flush_rdy_o,
  output logic [CW-1:0]    count_o
);
  localparam int SW = $clog2(LANES);
  localparam int PW = LANE_DEPTH > 1 ? $clog2(LANE_DEPTH) : 1;
  localparam int OW = $clog2(LANE_DEPTH + 1);
  logic [WIDTH-1:0] mem_q [LANES][LANE_DEPTH];
  logic [PW-1:0] rd_q [LANES], rd_d [LANES], wr_q [LANES], wr_d [LANES];
  logic [OW-1:0] occ_q [LANES], occ_d [LANES];
  logic [SW-1:0] enq_sel_q, enq_sel_d, deq_sel_q, deq_sel_d;
  logic [CW-1:0] count_q, count_d;
  logic enq_fire, deq_fire, clear;
  function automatic logic [SW-1:0] sel_inc(input logic [SW-1:0] s);
    return (s == SW'(LANES - 1)) ? '0 : s + SW'(1);
  endfunction
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LANE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign in_enq_rdy_o    = occ_q[enq_sel_q] != OW'(LANE_DEPTH);
  assign out_deq_rdy_o   = occ_q[deq_sel_q] != '0;
  assign out_first_rdy_o = out_deq_rdy_o;
  assign out_first_o     = out_deq_rdy_o ? mem_q[deq_sel_q][rd_q[deq_sel_q]] : '0;
  assign flush_rdy_o     = 1'b1;
  assign count_o         = count_q;
  assign enq_fire        = in_enq_ena_i && in_enq_rdy_o;
  assign deq_fire        = out_deq_ena_i && out_deq_rdy_o;
  assign clear           = RST || flush_ena_i;
  // a lane targeted by both selectors at once sees +1 and -1, netting to no occupancy change
  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    occ_d = occ_q;
    enq_sel_d = enq_sel_q;
    deq_sel_d = deq_sel_q;
    if (enq_fire) begin
      wr_d[enq_sel_q] = ptr_inc(wr_q[enq_sel_q]);
      occ_d[enq_sel_q] = occ_d[enq_sel_q] + OW'(1);
      enq_sel_d = sel_inc(enq_sel_q);
    end
    if (deq_fire) begin
      rd_d[deq_sel_q] = ptr_inc(rd_q[deq_sel_q]);
      occ_d[deq_sel_q] = occ_d[deq_sel_q] - OW'(1);
      deq_sel_d = sel_inc(deq_sel_q);
    end
    count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
  end
  always_ff @(posedge CLK) begin
    if (clear) begin
      rd_q <= '{default: '0};
      wr_q <= '{default: '0};
      occ_q <= '{default: '0};
      enq_sel_q <= '0;
      deq_sel_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
      enq_sel_q <= enq_sel_d;
      deq_sel_q <= deq_sel_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (enq_fire && !clear) mem_q[enq_sel_q][wr_q[enq_sel_q]] <= in_enq_v_i;
  end
  always_ff @(posedge CLK) begin
    if (!clear) begin
      assert (!(in_enq_ena_i && !in_enq_rdy_o));
      assert (!(out_deq_ena_i && !out_deq_rdy_o));
    end
  end
endmodule

// File: doc/fifo_rr_bank.md
Name: fifo_rr_bank

Overview:
Parametrised successor to the two-element ping-pong FIFO. LANES single-clock FIFO lanes, each LANE_DEPTH entries deep, sit behind independent round-robin enqueue and dequeue selectors, so the bank preserves global FIFO order at LANES*LANE_DEPTH total capacity. Adds an occupancy count and a synchronous flush. It drops into the message path between the request indication pipe and its consumer, with the same enq/deq/first interface as the ping-pong FIFO.

Parameters:
WIDTH, 704, payload width in bits (>=1)
LANES, 2, number of lanes (>=2; any integer, not restricted to a power of two)
LANE_DEPTH, 1, entries per lane (>=1)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous reset, active-high
in$enq__ENA  input  1  enqueue strobe; legal only while in$enq__RDY=1
in$enq$v  input  WIDTH  enqueue payload
in$enq__RDY  output  1  lane[enq_sel] not full
out$deq__ENA  input  1  dequeue strobe; legal only while out$deq__RDY=1
out$deq__RDY  output  1  lane[deq_sel] not empty
out$first  output  WIDTH  head of lane[deq_sel]; 0 when bank empty
out$first__RDY  output  1  identical to out$deq__RDY
flush__ENA  input  1  discard all contents
flush__RDY  output  1  constant 1
count  output  $clog2(LANES*LANE_DEPTH+1)  total entries held

Behaviour:
- State:
  - enq_sel, deq_sel: 0..LANES-1.
  - Per lane: circular buffer with its own rd_ptr, wr_ptr (0..LANE_DEPTH-1) and occupancy 0..LANE_DEPTH.
  - count register.
  - Storage is inline; no Fifo1 instances.
- Reset (RST=1 at posedge): all pointers, occupancies, selectors and count go to 0. Storage contents are not reset.
- Outputs after reset: in$enq__RDY=1, out$deq__RDY=0, out$first__RDY=0, out$first=0, count=0, flush__RDY=1.
- Enqueue fires when in$enq__ENA & in$enq__RDY:
  - writes in$enq$v at lane[enq_sel].wr_ptr;
  - increments that lane's wr_ptr (wrap LANE_DEPTH-1 -> 0) and occupancy;
  - enq_sel advances (wrap LANES-1 -> 0).
- Dequeue fires when out$deq__ENA & out$deq__RDY:
  - increments lane[deq_sel].rd_ptr (with wrap) and decrements its occupancy;
  - deq_sel advances (with wrap).
- Latency: data enqueued in cycle N is visible on out$first from cycle N+1 at the earliest. No bypass from in$enq$v to out$first.
- Ready signals depend only on registered state, never on the ENA inputs. A full lane never accepts a simultaneous enq+deq pass-through.
- Simultaneous enq and deq:
  - Both fire independently, including on the same lane. A lane with occupancy 1..LANE_DEPTH-1 both writes and reads in the same cycle.
  - Net count change: +1, -1 or 0.
- Ordering invariant: entry k (0-based, since last reset/flush) goes to lane k mod LANES. Dequeue order equals enqueue order.
- count = sum of lane occupancies. Range 0..LANES*LANE_DEPTH, with no saturation or wrap possible.
- flush__ENA: same effect as RST at the next edge. Priority over enq and deq in the same cycle; both are dropped and count goes to 0.
- RST mid-operation: overrides flush, enq and deq. No partial update.
- ENA without RDY: no state change. Flagged by a simulation-only assertion.
- out$first when out$first__RDY=0: drives 0, never stale data.

Test Plan:
- Use WIDTH=8, LANES=3, LANE_DEPTH=2 unless noted.
- Reset then idle → in$enq__RDY=1, out$deq__RDY=0, out$first=0, count=0 for 5 cycles.
- Enqueue 0x10..0x15 back-to-back (6 cycles) → after 6th, in$enq__RDY=0, count=6; then dequeue 6 → out$first sequence 0x10,0x11,…,0x15, count returns to 0, out$deq__RDY=0.
- Enq 0xA1, then 20 cycles of simultaneous enq (0xA2,0xA3,…) and deq → each dequeued value is the one enqueued the prior cycle, count stays 1, selectors wrap past lane 2 with order intact.
- Fill to 6 entries, assert flush__ENA together with out$deq__ENA and in$enq__ENA → next cycle count=0, out$deq__RDY=0; then enq 0x55 and deq → 0x55 returned.
- Enqueue 4 entries, assert RST for one cycle while also asserting out$deq__ENA → count=0, out$first=0; subsequent enq 0x77/deq → 0x77.
- LANES=2, LANE_DEPTH=1, WIDTH=704 → fills after 2 entries, in$enq__RDY=0; dequeue yields enqueue order; count saturates at 2 without wrap.
